// File: rtl/axi_lii_pkg.sv
// Shared encodings, header field widths and header pack/unpack helpers for the
// AXI4-to-LII bridge.
package axi_lii_pkg;

    localparam int OP_W       = 2;
    localparam int LEN_W      = 8;
    localparam int SIZE_W     = 3;
    localparam int TAG_W      = 8;
    localparam int RESP_W     = 2;
    localparam int REQ_CTL_W  = OP_W + LEN_W + SIZE_W;
    localparam int RESP_HDR_W = OP_W + RESP_W + TAG_W;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_RD_RESP = 2'b10;
    localparam logic [1:0] OP_WR_ACK  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_HDR_RD,
        REQ_HDR_WR,
        REQ_SEND_W
    } req_state_t;

    typedef enum logic [1:0] {
        RSP_R_HDR,
        RSP_R_DATA,
        RSP_B_OUT,
        RSP_DRAIN
    } rsp_state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [RESP_W-1:0] resp;
        logic [TAG_W-1:0]  tag;
    } resp_hdr_t;

    // Fixed-width leading part of a request header; address and tag follow it.
    function automatic logic [REQ_CTL_W-1:0] pack_req_ctl(
        input logic [OP_W-1:0]   op,
        input logic [LEN_W-1:0]  len,
        input logic [SIZE_W-1:0] size
    );
        return {op, len, size};
    endfunction

    // Splits the top bits of a response flit into op/resp/tag.
    function automatic resp_hdr_t unpack_resp_hdr(input logic [RESP_HDR_W-1:0] bits);
        return resp_hdr_t'(bits);
    endfunction

endpackage

// File: rtl/axi_lii_bridge_tag_fifo.sv
// In-order tag FIFO: remembers which tag the next response of one direction
// must carry. Occupancy doubles as the outstanding-transaction count.
module tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; push and pop together leave the count alone.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lii_bridge.sv
// AXI4 slave to LII request/response bridge. AR/AW are arbitrated round-robin
// into request headers (writes followed by their W beats); response packets are
// checked against in-order expected tags and turned into R and B beats.
module axi_lii_bridge
    import axi_lii_pkg::*;
#(
    parameter int AXI_AW  = 48,
    parameter int AXI_DW  = 64,
    parameter int LII_DW  = 128,
    parameter int MAX_OUT = 4
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic [AXI_AW-1:0]   aximm_araddr,
    input  logic [7:0]          aximm_arlen,
    input  logic [2:0]          aximm_arsize,
    input  logic                aximm_arvalid,
    output logic                aximm_arready,

    input  logic [AXI_AW-1:0]   aximm_awaddr,
    input  logic [7:0]          aximm_awlen,
    input  logic [2:0]          aximm_awsize,
    input  logic                aximm_awvalid,
    output logic                aximm_awready,

    input  logic [AXI_DW-1:0]   aximm_wdata,
    input  logic [AXI_DW/8-1:0] aximm_wstrb,
    input  logic                aximm_wlast,
    input  logic                aximm_wvalid,
    output logic                aximm_wready,

    output logic [AXI_DW-1:0]   aximm_rdata,
    output logic [1:0]          aximm_rresp,
    output logic                aximm_rlast,
    output logic                aximm_rvalid,
    input  logic                aximm_rready,

    output logic [1:0]          aximm_bresp,
    output logic                aximm_bvalid,
    input  logic                aximm_bready,

    output logic [LII_DW-1:0]   lii_req_tdata,
    output logic [LII_DW/8-1:0] lii_req_tkeep,
    output logic [LII_DW/8-1:0] lii_req_tstrb,
    output logic                lii_req_tlast,
    output logic [7:0]          lii_req_src,
    output logic [7:0]          lii_req_dst,
    output logic                lii_req_tvalid,
    input  logic                lii_req_tready,

    input  logic [LII_DW-1:0]   lii_resp_tdata,
    input  logic [LII_DW/8-1:0] lii_resp_tkeep,
    input  logic [LII_DW/8-1:0] lii_resp_tstrb,
    input  logic                lii_resp_tlast,
    input  logic [7:0]          lii_resp_src,
    input  logic [7:0]          lii_resp_dst,
    input  logic                lii_resp_tvalid,
    output logic                lii_resp_tready,

    input  logic [7:0]          cfg_src,
    input  logic [7:0]          cfg_dst,
    output logic                err_tag_mismatch,
    output logic                err_unexpected,
    input  logic                err_clr
);

    localparam int CW        = $clog2(MAX_OUT);
    localparam int REQ_HDR_W = REQ_CTL_W + AXI_AW + TAG_W;

    req_state_t             req_state, req_next;
    rsp_state_t             rsp_state, rsp_next;
    logic                   prefer_ar;
    logic [LII_DW-1:0]      hdr_q;
    logic [CW-1:0]          rd_ctr, wr_ctr;
    logic [TAG_W-1:0]       rd_tag, wr_tag;
    logic                   grant_ar, grant_aw;
    logic                   ar_elig, aw_elig;
    logic [LII_DW-1:0]      w_flit;
    logic [LII_DW/8-1:0]    w_keep;

    logic                   rd_full, rd_empty, wr_full, wr_empty;
    logic [TAG_W-1:0]       rd_head, wr_head;
    logic                   rd_pop, wr_pop;

    resp_hdr_t              rh;
    logic                   rd_expected, wr_expected;
    logic [1:0]             resp_q, resp_d;
    logic                   set_mismatch, set_unexp;
    logic                   unused_resp_bits;

    // Response sideband and payload bits above the R data are never interpreted.
    assign unused_resp_bits = ^{lii_resp_tdata, lii_resp_tkeep, lii_resp_tstrb,
                                lii_resp_src, lii_resp_dst};

    assign lii_req_src = cfg_src;
    assign lii_req_dst = cfg_dst;
    assign rd_tag      = {1'b0, 7'(rd_ctr)};
    assign wr_tag      = {1'b1, 7'(wr_ctr)};
    assign ar_elig     = aximm_arvalid && !rd_full;
    assign aw_elig     = aximm_awvalid && !wr_full;

    // Header layout with the populated fields at the MSB end, remainder zero.
    function automatic logic [LII_DW-1:0] build_req_hdr(
        input logic [1:0]        op,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [AXI_AW-1:0] addr,
        input logic [TAG_W-1:0]  tag
    );
        logic [LII_DW-1:0] h;
        h = '0;
        h[LII_DW-1 -: REQ_HDR_W] = {pack_req_ctl(op, len, size), addr, tag};
        return h;
    endfunction

    // W beats sit in the low bits of a data flit; keep/strobe mirror wstrb.
    always_comb begin
        w_flit = '0;
        w_keep = '0;
        w_flit[AXI_DW-1:0]   = aximm_wdata;
        w_keep[AXI_DW/8-1:0] = aximm_wstrb;
    end

    tag_fifo #(.DEPTH(MAX_OUT), .WIDTH(TAG_W)) u_rd_tags (
        .clk   (clk),
        .rstn  (rstn),
        .push  (grant_ar),
        .pop   (rd_pop),
        .din   (rd_tag),
        .full  (rd_full),
        .empty (rd_empty),
        .head  (rd_head)
    );

    tag_fifo #(.DEPTH(MAX_OUT), .WIDTH(TAG_W)) u_wr_tags (
        .clk   (clk),
        .rstn  (rstn),
        .push  (grant_aw),
        .pop   (wr_pop),
        .din   (wr_tag),
        .full  (wr_full),
        .empty (wr_empty),
        .head  (wr_head)
    );

    // Request side: arbitration in IDLE, then header and (for writes) W beats.
    always_comb begin
        req_next       = req_state;
        grant_ar       = 1'b0;
        grant_aw       = 1'b0;
        aximm_arready  = 1'b0;
        aximm_awready  = 1'b0;
        aximm_wready   = 1'b0;
        lii_req_tvalid = 1'b0;
        lii_req_tdata  = hdr_q;
        lii_req_tkeep  = '1;
        lii_req_tstrb  = '0;
        lii_req_tlast  = 1'b0;
        case (req_state)
            REQ_IDLE: begin
                if (rstn) begin
                    if (ar_elig && (!aw_elig || prefer_ar)) begin
                        grant_ar = 1'b1;
                        req_next = REQ_HDR_RD;
                    end else if (aw_elig) begin
                        grant_aw = 1'b1;
                        req_next = REQ_HDR_WR;
                    end
                    aximm_arready = grant_ar;
                    aximm_awready = grant_aw;
                end
            end
            REQ_HDR_RD: begin
                lii_req_tvalid = 1'b1;
                lii_req_tlast  = 1'b1;
                if (lii_req_tready) begin
                    req_next = REQ_IDLE;
                end
            end
            REQ_HDR_WR: begin
                lii_req_tvalid = 1'b1;
                if (lii_req_tready) begin
                    req_next = REQ_SEND_W;
                end
            end
            REQ_SEND_W: begin
                lii_req_tvalid = aximm_wvalid;
                aximm_wready   = lii_req_tready;
                lii_req_tdata  = w_flit;
                lii_req_tkeep  = w_keep;
                lii_req_tstrb  = w_keep;
                lii_req_tlast  = aximm_wlast;
                if (aximm_wvalid && lii_req_tready && aximm_wlast) begin
                    req_next = REQ_IDLE;
                end
            end
            default: req_next = REQ_IDLE;
        endcase
    end

    // Request state, round-robin pointer, header register and tag counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            req_state <= REQ_IDLE;
            prefer_ar <= 1'b0;
            hdr_q     <= '0;
            rd_ctr    <= '0;
            wr_ctr    <= '0;
        end else begin
            req_state <= req_next;
            if (grant_ar) begin
                hdr_q     <= build_req_hdr(OP_READ, aximm_arlen, aximm_arsize, aximm_araddr, rd_tag);
                rd_ctr    <= rd_ctr + 1'b1;
                prefer_ar <= 1'b0;
            end else if (grant_aw) begin
                hdr_q     <= build_req_hdr(OP_WRITE, aximm_awlen, aximm_awsize, aximm_awaddr, wr_tag);
                wr_ctr    <= wr_ctr + 1'b1;
                prefer_ar <= 1'b1;
            end
        end
    end

    assign rh          = unpack_resp_hdr(lii_resp_tdata[LII_DW-1 -: RESP_HDR_W]);
    assign rd_expected = (rh.op == OP_RD_RESP) && !rd_empty && !lii_resp_tlast;
    assign wr_expected = (rh.op == OP_WR_ACK) && !wr_empty && lii_resp_tlast;

    // Response side: decode header, stream R beats, present B, or drain junk.
    always_comb begin
        rsp_next        = rsp_state;
        lii_resp_tready = 1'b0;
        aximm_rvalid    = 1'b0;
        aximm_rdata     = lii_resp_tdata[AXI_DW-1:0];
        aximm_rresp     = resp_q;
        aximm_rlast     = lii_resp_tlast;
        aximm_bvalid    = 1'b0;
        aximm_bresp     = resp_q;
        rd_pop          = 1'b0;
        wr_pop          = 1'b0;
        resp_d          = resp_q;
        set_mismatch    = 1'b0;
        set_unexp       = 1'b0;
        case (rsp_state)
            RSP_R_HDR: begin
                if (rstn) begin
                    lii_resp_tready = 1'b1;
                    if (lii_resp_tvalid) begin
                        if (rd_expected) begin
                            set_mismatch = (rh.tag != rd_head);
                            resp_d       = set_mismatch ? RESP_SLVERR : rh.resp;
                            rsp_next     = RSP_R_DATA;
                        end else if (wr_expected) begin
                            set_mismatch = (rh.tag != wr_head);
                            resp_d       = set_mismatch ? RESP_SLVERR : rh.resp;
                            rsp_next     = RSP_B_OUT;
                        end else begin
                            set_unexp = 1'b1;
                            if (!lii_resp_tlast) begin
                                rsp_next = RSP_DRAIN;
                            end
                        end
                    end
                end
            end
            RSP_R_DATA: begin
                aximm_rvalid    = lii_resp_tvalid;
                lii_resp_tready = aximm_rready;
                if (lii_resp_tvalid && aximm_rready && lii_resp_tlast) begin
                    rd_pop   = 1'b1;
                    rsp_next = RSP_R_HDR;
                end
            end
            RSP_B_OUT: begin
                aximm_bvalid = 1'b1;
                if (aximm_bready) begin
                    wr_pop   = 1'b1;
                    rsp_next = RSP_R_HDR;
                end
            end
            RSP_DRAIN: begin
                lii_resp_tready = 1'b1;
                if (lii_resp_tvalid && lii_resp_tlast) begin
                    rsp_next = RSP_R_HDR;
                end
            end
            default: rsp_next = RSP_R_HDR;
        endcase
    end

    // Response state and the response code latched from the header.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_state <= RSP_R_HDR;
            resp_q    <= RESP_OKAY;
        end else begin
            rsp_state <= rsp_next;
            resp_q    <= resp_d;
        end
    end

    // Sticky error flags; a clear wins over an error arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_tag_mismatch <= 1'b0;
            err_unexpected   <= 1'b0;
        end else if (err_clr) begin
            err_tag_mismatch <= 1'b0;
            err_unexpected   <= 1'b0;
        end else begin
            if (set_mismatch) begin
                err_tag_mismatch <= 1'b1;
            end
            if (set_unexp) begin
                err_unexpected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lii_bridge.sv
// Directed bench for axi_lii_bridge: read, write, arbitration, outstanding
// limit, tag mismatch, unexpected responses and mid-packet reset.
module tb_axi_lii_bridge;

    localparam int AW = 48;
    localparam int DW = 64;
    localparam int LW = 128;
    localparam int KW = LW / 8;

    logic clk = 1'b0;
    logic rstn;

    logic [AW-1:0]   araddr, awaddr;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, awsize;
    logic            arvalid, arready, awvalid, awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast, wvalid, wready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp, bresp;
    logic            rlast, rvalid, rready, bvalid, bready;
    logic [LW-1:0]   req_tdata, resp_tdata;
    logic [KW-1:0]   req_tkeep, req_tstrb, resp_tkeep, resp_tstrb;
    logic            req_tlast, req_tvalid, req_tready;
    logic [7:0]      req_src, req_dst, resp_src, resp_dst;
    logic            resp_tlast, resp_tvalid, resp_tready;
    logic [7:0]      cfg_src, cfg_dst;
    logic            err_tm, err_ue, err_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_lii_bridge #(.AXI_AW(AW), .AXI_DW(DW), .LII_DW(LW), .MAX_OUT(4)) dut (
        .clk (clk), .rstn (rstn),
        .aximm_araddr (araddr), .aximm_arlen (arlen), .aximm_arsize (arsize),
        .aximm_arvalid (arvalid), .aximm_arready (arready),
        .aximm_awaddr (awaddr), .aximm_awlen (awlen), .aximm_awsize (awsize),
        .aximm_awvalid (awvalid), .aximm_awready (awready),
        .aximm_wdata (wdata), .aximm_wstrb (wstrb), .aximm_wlast (wlast),
        .aximm_wvalid (wvalid), .aximm_wready (wready),
        .aximm_rdata (rdata), .aximm_rresp (rresp), .aximm_rlast (rlast),
        .aximm_rvalid (rvalid), .aximm_rready (rready),
        .aximm_bresp (bresp), .aximm_bvalid (bvalid), .aximm_bready (bready),
        .lii_req_tdata (req_tdata), .lii_req_tkeep (req_tkeep), .lii_req_tstrb (req_tstrb),
        .lii_req_tlast (req_tlast), .lii_req_src (req_src), .lii_req_dst (req_dst),
        .lii_req_tvalid (req_tvalid), .lii_req_tready (req_tready),
        .lii_resp_tdata (resp_tdata), .lii_resp_tkeep (resp_tkeep), .lii_resp_tstrb (resp_tstrb),
        .lii_resp_tlast (resp_tlast), .lii_resp_src (resp_src), .lii_resp_dst (resp_dst),
        .lii_resp_tvalid (resp_tvalid), .lii_resp_tready (resp_tready),
        .cfg_src (cfg_src), .cfg_dst (cfg_dst),
        .err_tag_mismatch (err_tm), .err_unexpected (err_ue), .err_clr (err_clr)
    );

    // Expected request header: op[127:126] len[125:118] size[117:115] addr[114:67] tag[66:59].
    function automatic logic [LW-1:0] req_hdr(input logic [1:0] op, input logic [7:0] len,
                                              input logic [2:0] size, input logic [47:0] addr,
                                              input logic [7:0] tag);
        logic [LW-1:0] h;
        h = '0;
        h[127:126] = op;
        h[125:118] = len;
        h[117:115] = size;
        h[114:67]  = addr;
        h[66:59]   = tag;
        return h;
    endfunction

    // Response header: op[127:126] resp[125:124] tag[123:116].
    function automatic logic [LW-1:0] resp_hdr(input logic [1:0] op, input logic [1:0] resp,
                                               input logic [7:0] tag);
        logic [LW-1:0] h;
        h = '0;
        h[127:126] = op;
        h[125:124] = resp;
        h[123:116] = tag;
        return h;
    endfunction

    task automatic idle_inputs();
        araddr = '0; arlen = '0; arsize = 3'd3; arvalid = 1'b0;
        awaddr = '0; awlen = '0; awsize = 3'd3; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b1; bready = 1'b1; req_tready = 1'b1;
        resp_tdata = '0; resp_tkeep = '1; resp_tstrb = '0; resp_tlast = 1'b0;
        resp_src = 8'h34; resp_dst = 8'h12; resp_tvalid = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        $display("[TB] test_reset");
        @(negedge clk);
        idle_inputs();
        rstn = 1'b0;
        arvalid = 1'b1;
        awvalid = 1'b1;
        resp_tvalid = 1'b1;
        resp_tdata = resp_hdr(2'b10, 2'b00, 8'h00);
        @(negedge clk);
        #1;
        obs = {arready, awready, wready, req_tvalid, rvalid, bvalid, resp_tready, err_tm, err_ue};
        total++;
        if (obs !== 9'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b want %b", obs, 9'h0);
        end
        total++;
        if ({req_src, req_dst} !== {cfg_src, cfg_dst}) begin
            bad++;
            $display("[TB] FAIL reset_route: got %h want %h", {req_src, req_dst}, {cfg_src, cfg_dst});
        end
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        #1;
        total++;
        if ({resp_tready, arready, req_tvalid} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL post_reset_idle: got %b want %b", {resp_tready, arready, req_tvalid}, 3'b100);
        end
    endtask

    task automatic test_single_read();
        $display("[TB] test_single_read");
        do_reset();
        @(negedge clk);
        araddr = 48'h1000; arlen = 8'd3; arsize = 3'd3; arvalid = 1'b1;
        #1;
        total++;
        if (arready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rd_arready: got %b want 1", arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        total++;
        if ({req_tvalid, req_tlast, req_tkeep, req_tstrb} !== {1'b1, 1'b1, 16'hFFFF, 16'h0000}) begin
            bad++;
            $display("[TB] FAIL rd_hdr_ctl: got %h want %h", {req_tvalid, req_tlast, req_tkeep, req_tstrb},
                     {1'b1, 1'b1, 16'hFFFF, 16'h0000});
        end
        total++;
        if (req_tdata !== req_hdr(2'b00, 8'd3, 3'd3, 48'h1000, 8'h00)) begin
            bad++;
            $display("[TB] FAIL rd_hdr_data: got %h want %h", req_tdata, req_hdr(2'b00, 8'd3, 3'd3, 48'h1000, 8'h00));
        end
        @(negedge clk);
        resp_tvalid = 1'b1; resp_tdata = resp_hdr(2'b10, 2'b00, 8'h00); resp_tlast = 1'b0;
        #1;
        total++;
        if ({resp_tready, req_tvalid, rvalid} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL rd_resp_hdr: got %b want %b", {resp_tready, req_tvalid, rvalid}, 3'b100);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            resp_tdata = {64'h0, 64'hD000 + 64'(i)};
            resp_tlast = (i == 3);
            #1;
            total++;
            if ({rvalid, rdata, rresp, rlast} !== {1'b1, 64'hD000 + 64'(i), 2'b00, (i == 3)}) begin
                bad++;
                $display("[TB] FAIL rd_beat%0d: got %h want %h", i, {rvalid, rdata, rresp, rlast},
                         {1'b1, 64'hD000 + 64'(i), 2'b00, (i == 3)});
            end
        end
        @(negedge clk);
        resp_tvalid = 1'b0; resp_tlast = 1'b0;
        #1;
        total++;
        if ({rvalid, err_tm, err_ue} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL rd_done: got %b want %b", {rvalid, err_tm, err_ue}, 3'b000);
        end
    endtask

    task automatic test_write();
        $display("[TB] test_write");
        do_reset();
        @(negedge clk);
        awaddr = 48'h2000; awlen = 8'd1; awsize = 3'd3; awvalid = 1'b1;
        #1;
        total++;
        if ({awready, arready} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL wr_awready: got %b want %b", {awready, arready}, 2'b10);
        end
        @(negedge clk);
        awvalid = 1'b0;
        #1;
        total++;
        if ({req_tvalid, req_tlast, req_tdata} !== {1'b1, 1'b0, req_hdr(2'b01, 8'd1, 3'd3, 48'h2000, 8'h80)}) begin
            bad++;
            $display("[TB] FAIL wr_hdr: got %h want %h", {req_tvalid, req_tlast, req_tdata},
                     {1'b1, 1'b0, req_hdr(2'b01, 8'd1, 3'd3, 48'h2000, 8'h80)});
        end
        @(negedge clk);
        wvalid = 1'b1; wdata = 64'h1111_2222_3333_4444; wstrb = 8'hFF; wlast = 1'b0;
        #1;
        total++;
        if ({req_tvalid, wready, req_tlast, req_tkeep, req_tstrb, req_tdata} !==
            {1'b1, 1'b1, 1'b0, 16'h00FF, 16'h00FF, 64'h0, 64'h1111_2222_3333_4444}) begin
            bad++;
            $display("[TB] FAIL wr_beat0: got %h want %h", {req_tvalid, wready, req_tlast, req_tkeep, req_tstrb, req_tdata},
                     {1'b1, 1'b1, 1'b0, 16'h00FF, 16'h00FF, 64'h0, 64'h1111_2222_3333_4444});
        end
        @(negedge clk);
        wdata = 64'h5555_6666_7777_8888; wstrb = 8'h0F; wlast = 1'b1;
        #1;
        total++;
        if ({req_tvalid, wready, req_tlast, req_tkeep, req_tstrb, req_tdata} !==
            {1'b1, 1'b1, 1'b1, 16'h000F, 16'h000F, 64'h0, 64'h5555_6666_7777_8888}) begin
            bad++;
            $display("[TB] FAIL wr_beat1: got %h want %h", {req_tvalid, wready, req_tlast, req_tkeep, req_tstrb, req_tdata},
                     {1'b1, 1'b1, 1'b1, 16'h000F, 16'h000F, 64'h0, 64'h5555_6666_7777_8888});
        end
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        resp_tvalid = 1'b1; resp_tdata = resp_hdr(2'b11, 2'b00, 8'h80); resp_tlast = 1'b1;
        #1;
        total++;
        if ({resp_tready, req_tvalid, bvalid} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL wr_ack_hdr: got %b want %b", {resp_tready, req_tvalid, bvalid}, 3'b100);
        end
        @(negedge clk);
        resp_tvalid = 1'b0; resp_tlast = 1'b0;
        #1;
        total++;
        if ({bvalid, bresp, resp_tready} !== {1'b1, 2'b00, 1'b0}) begin
            bad++;
            $display("[TB] FAIL wr_bvalid: got %b want %b", {bvalid, bresp, resp_tready}, {1'b1, 2'b00, 1'b0});
        end
        @(negedge clk);
        bready = 1'b1;
        #1;
        total++;
        if (bvalid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wr_bhold: got %b want 1", bvalid);
        end
        @(negedge clk);
        #1;
        total++;
        if ({bvalid, err_tm, err_ue} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL wr_bdone: got %b want %b", {bvalid, err_tm, err_ue}, 3'b000);
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] seq;
        int n;
        int both;
        $display("[TB] test_arbitration");
        do_reset();
        seq = '0;
        n = 0;
        both = 0;
        @(negedge clk);
        arvalid = 1'b1; araddr = 48'hA000; awvalid = 1'b1; awaddr = 48'hB000;
        wvalid = 1'b1; wlast = 1'b1; wstrb = 8'hFF; wdata = 64'hCAFE;
        for (int i = 0; i < 40 && n < 4; i++) begin
            #1;
            if (arready && awready) both++;
            if (awready) begin
                seq = {seq[2:0], 1'b1};
                n++;
            end else if (arready) begin
                seq = {seq[2:0], 1'b0};
                n++;
            end
            @(negedge clk);
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        total++;
        if (n !== 4) begin
            bad++;
            $display("[TB] FAIL arb_timeout: got %0d grants want 4", n);
        end
        total++;
        if (seq !== 4'b1010) begin
            bad++;
            $display("[TB] FAIL arb_order: got %b want %b (1=AW)", seq, 4'b1010);
        end
        total++;
        if (both !== 0) begin
            bad++;
            $display("[TB] FAIL arb_double_grant: got %0d want 0", both);
        end
    endtask

    task automatic test_max_outstanding();
        $display("[TB] test_max_outstanding");
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            araddr = 48'h3000 + 48'(k * 64); arlen = 8'd0; arvalid = 1'b1;
            #1;
            total++;
            if (arready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL fill_ar%0d: got %b want 1", k, arready);
            end
            @(negedge clk);
            arvalid = 1'b0;
        end
        @(negedge clk);
        araddr = 48'h3400; arvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (arready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL full_block%0d: got %b want 0", c, arready);
            end
            @(negedge clk);
        end
        resp_tvalid = 1'b1; resp_tdata = resp_hdr(2'b10, 2'b00, 8'h00); resp_tlast = 1'b0;
        #1;
        @(negedge clk);
        resp_tdata = {64'h0, 64'hBEEF}; resp_tlast = 1'b1;
        #1;
        total++;
        if ({arready, rvalid, rlast, rresp} !== {1'b0, 1'b1, 1'b1, 2'b00}) begin
            bad++;
            $display("[TB] FAIL full_last_beat: got %b want %b", {arready, rvalid, rlast, rresp}, {1'b0, 1'b1, 1'b1, 2'b00});
        end
        @(negedge clk);
        resp_tvalid = 1'b0; resp_tlast = 1'b0;
        #1;
        total++;
        if (arready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_release: got %b want 1", arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic test_tag_mismatch();
        $display("[TB] test_tag_mismatch");
        do_reset();
        @(negedge clk);
        araddr = 48'h4000; arlen = 8'd0; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        resp_tvalid = 1'b1; resp_tdata = resp_hdr(2'b10, 2'b00, 8'h01); resp_tlast = 1'b0;
        @(negedge clk);
        resp_tdata = {64'h0, 64'h1234}; resp_tlast = 1'b1;
        #1;
        total++;
        if ({rvalid, rresp, rlast, rdata} !== {1'b1, 2'b10, 1'b1, 64'h1234}) begin
            bad++;
            $display("[TB] FAIL mm_beat: got %h want %h", {rvalid, rresp, rlast, rdata}, {1'b1, 2'b10, 1'b1, 64'h1234});
        end
        total++;
        if ({err_tm, err_ue} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL mm_flags: got %b want %b", {err_tm, err_ue}, 2'b10);
        end
        @(negedge clk);
        resp_tvalid = 1'b0; resp_tlast = 1'b0; err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        total++;
        if (err_tm !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mm_clear: got %b want 0", err_tm);
        end
        // Head was popped, so a further read response has nothing to match.
        resp_tvalid = 1'b1; resp_tdata = resp_hdr(2'b10, 2'b00, 8'h00); resp_tlast = 1'b0;
        @(negedge clk);
        resp_tdata = {64'h0, 64'h5678}; resp_tlast = 1'b1;
        #1;
        total++;
        if ({rvalid, resp_tready, err_ue} !== 3'b011) begin
            bad++;
            $display("[TB] FAIL mm_drain: got %b want %b", {rvalid, resp_tready, err_ue}, 3'b011);
        end
        @(negedge clk);
        resp_tdata = resp_hdr(2'b00, 2'b00, 8'h00); resp_tlast = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        resp_tvalid = 1'b0; resp_tlast = 1'b0; err_clr = 1'b0;
        #1;
        total++;
        if (err_ue !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clr_priority: got %b want 0", err_ue);
        end
    endtask

    task automatic test_unexpected_and_reset();
        logic [7:0] obs;
        $display("[TB] test_unexpected_and_reset");
        do_reset();
        @(negedge clk);
        resp_tvalid = 1'b1; resp_tdata = resp_hdr(2'b11, 2'b00, 8'h80); resp_tlast = 1'b1;
        #1;
        total++;
        if (resp_tready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ue_tready: got %b want 1", resp_tready);
        end
        @(negedge clk);
        resp_tvalid = 1'b0; resp_tlast = 1'b0;
        #1;
        total++;
        if ({bvalid, err_ue, err_tm} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL ue_flags: got %b want %b", {bvalid, err_ue, err_tm}, 3'b010);
        end
        araddr = 48'h5000; arlen = 8'd3; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        araddr = 48'h6000; arlen = 8'd1; arvalid = 1'b1; req_tready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        resp_tvalid = 1'b1; resp_tdata = resp_hdr(2'b10, 2'b00, 8'h00); resp_tlast = 1'b0;
        @(negedge clk);
        resp_tdata = {64'h0, 64'h9999}; rready = 1'b0;
        #1;
        total++;
        if ({req_tvalid, rvalid, resp_tready} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL mid_state: got %b want %b", {req_tvalid, rvalid, resp_tready}, 3'b110);
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        obs = {req_tvalid, rvalid, bvalid, arready, resp_tready, wready, err_ue, err_tm};
        total++;
        if (obs !== 8'h00) begin
            bad++;
            $display("[TB] FAIL mid_reset: got %b want %b", obs, 8'h00);
        end
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        @(negedge clk);
        araddr = 48'h7000; arlen = 8'd0; arsize = 3'd2; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        total++;
        if (req_tdata !== req_hdr(2'b00, 8'd0, 3'd2, 48'h7000, 8'h00)) begin
            bad++;
            $display("[TB] FAIL post_reset_tag: got %h want %h", req_tdata, req_hdr(2'b00, 8'd0, 3'd2, 48'h7000, 8'h00));
        end
    endtask

    initial begin
        rstn = 1'b0;
        cfg_src = 8'h12;
        cfg_dst = 8'h34;
        idle_inputs();
        test_reset();
        test_single_read();
        test_write();
        test_arbitration();
        test_max_outstanding();
        test_tag_mismatch();
        test_unexpected_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lii_bridge.md
# axi_lii_bridge

AXI4 slave to LII request/response stream bridge with up to MAX_OUT outstanding transactions per direction, internal tag allocation and explicit response-header decoding. It sits between an AXI4 master port and the LII network interface, serialising AW/AR/W traffic into LII request packets and turning LII response packets back into R and B beats. It supersedes single-outstanding bridging: it adds tag tracking, fair AR/AW arbitration and error reporting on malformed responses.

## Interface
- AXI_AW, 48, AXI address width
- AXI_DW, 64, AXI data width; must be ≤ LII_DW and a multiple of 8
- LII_DW, 128, LII flit width; must be ≥ 2+8+3+AXI_AW+8
- MAX_OUT, 4, outstanding transactions per direction (power of two, 2–16)
- clk  in  1  clock; one clock domain
- rstn  in  1  reset, synchronous, active-low
- aximm_ar*/aw*/w*  in/out  standard AXI4 subset (addr, len[8], size[3], valid/ready; wdata, wstrb, wlast)
- aximm_r*  out/in  rdata[AXI_DW], rresp[2], rlast, rvalid / rready
- aximm_b*  out/in  bresp[2], bvalid / bready
- lii_req_*  out/in  tdata[LII_DW], tkeep/tstrb[LII_DW/8], tlast, src[8], dst[8], tvalid / tready
- lii_resp_*  in/out  same fields, reverse direction
- cfg_src, cfg_dst  in  8 each  static route, driven on every request flit
- err_tag_mismatch  out  1  sticky; response tag ≠ expected head tag
- err_unexpected  out  1  sticky; response with no matching outstanding transaction
- err_clr  in  1  clears both sticky flags

## Operation
- Request header flit (MSB-packed): op[2] (00 READ, 01 WRITE), len[8], size[3], addr[AXI_AW], tag[8]; rest zero; tkeep all ones, tstrb zero.
- Request FSM: IDLE → HDR_RD → IDLE (tlast=1); IDLE → HDR_WR → SEND_W → IDLE after W beat with wlast.
- IDLE arbitration: round-robin between AR and AW when both valid; a channel is eligible only if its outstanding count < MAX_OUT. Winner's ready asserted for one cycle; address/len/size latched.
- Tags: read tags = {1'b0, rd_ctr}, write tags = {1'b1, wr_ctr}; counters modulo MAX_OUT increment per accepted address. Each tag pushed into a per-direction in-order expected-tag FIFO (depth MAX_OUT).
- SEND_W: wready = lii_req_tready; wdata in low AXI_DW bits; tkeep/tstrb low bytes = wstrb, upper bytes zero; tlast = wlast.
- Response header flit at MSB: op[2] (10 RD_RESP, 11 WR_ACK), resp[2], tag[8].
- Response FSM: R_HDR → (RD_RESP) R_DATA until data flit with tlast → R_HDR; (WR_ACK, tlast=1) → B_OUT → R_HDR.
- RD_RESP: header consumed with tready=1, resp and tag latched; data flits drive R with rresp = latched resp, rlast = tlast; lii_resp_tready = rready. Expected-read FIFO popped on last beat.
- WR_ACK: bvalid held until bready; bresp = header resp; FIFO popped on B handshake.
- Tag mismatch: deliver anyway with resp forced to 2'b10 (SLVERR), set err_tag_mismatch, pop head.
- Response for empty FIFO or op 00/01: flits drained (tready=1) until tlast, nothing issued on R/B, err_unexpected set.
- Outstanding count = FIFO occupancy; simultaneous push and pop leaves count unchanged.

## Timing
- Reset: all valids/readies 0, FSMs to IDLE / R_HDR, counters, FIFOs, sticky flags zero; src/dst follow cfg.
- AR/AW ready: combinational in IDLE, at most one per cycle; header valid the cycle after acceptance, registered and stable until tready.
- W path combinational through to LII (zero latency).
- R/B: combinational from lii_resp flit; B registered, 1 cycle after WR_ACK accepted.
- err_clr has priority over a same-cycle error set.
- Reset mid-packet abandons all state; outstanding transactions are forgotten.

## Structure
- Package axi_lii_pkg: op encodings, RESP_OKAY/RESP_SLVERR, header field widths, pack/unpack functions.
- Sub-module tag_fifo (depth MAX_OUT, width 8, push/pop/full/empty/head), instanced twice.

## Test plan
- Single read len=3 at 0x1000: header op=00 len=3 tag=0x00; response header tag 0x00 + 4 data flits → 4 R beats, rlast on 4th, rresp=00.
- Write len=1, wstrb 0xFF/0x0F: header op=01 tag=0x80, two data flits with tkeep 0x00FF/0x000F, last tlast=1; WR_ACK resp=00 → one B beat.
- AR and AW valid together for 4 cycles: accepts alternate AW, AR, AW, AR.
- MAX_OUT=4 reads issued, no responses: fifth arvalid sees arready=0 until first read completes.
- RD_RESP with tag 0x01 while head 0x00: R beats with rresp=10, err_tag_mismatch=1, cleared by err_clr.
- WR_ACK with no write outstanding: drained, no bvalid, err_unexpected=1; rstn low mid-burst → all outputs back to reset values next cycle.
